// File: rtl/bcd_date_entry_pkg.sv
// Shared definitions for the BCD date entry block: FSM states, digit layout and
// the month/day range check applied when the last digit is committed.
package bcd_date_entry_pkg;

    typedef enum logic {
        ST_ENTRY = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    localparam int          DIGITS    = 6;
    localparam logic [3:0]  BCD_MAX   = 4'd9;
    localparam logic [2:0]  LAST_POS  = 3'd5;
    localparam logic [2:0]  DONE_POS  = 3'd6;

    localparam int          MM_HI     = 23;
    localparam int          MM_LO     = 16;
    localparam int          DD_HI     = 15;
    localparam int          DD_LO     = 8;

    localparam logic [7:0]  MONTH_MIN = 8'h01;
    localparam logic [7:0]  MONTH_MAX = 8'h12;
    localparam logic [7:0]  DAY_MIN   = 8'h01;
    localparam logic [7:0]  DAY_MAX   = 8'h31;

    // Nibbles are always 0..9, so packed-BCD bytes order the same as binary.
    function automatic logic range_ok(input logic [23:0] d);
        logic [7:0] mm;
        logic [7:0] dd;
        mm = d[MM_HI:MM_LO];
        dd = d[DD_HI:DD_LO];
        return (mm >= MONTH_MIN) && (mm <= MONTH_MAX) &&
               (dd >= DAY_MIN) && (dd <= DAY_MAX);
    endfunction

endpackage

// File: rtl/bcd_date_entry_key_debounce.sv
// Debounces one synchronised active-low key and emits a single-cycle press pulse
// on the debounced falling edge. Presses are only armed once the key is seen released.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_sync,
    output logic level,
    output logic press_pulse
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] arm_cnt_q, arm_cnt_d;
    logic          press_q, press_d;

    always_comb begin
        level_d   = level_q;
        cnt_d     = '0;
        armed_d   = armed_q;
        arm_cnt_d = '0;
        if (key_n_sync != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // A key held through reset must be released (stably) before it can fire.
        if (!armed_q && key_n_sync) begin
            if (arm_cnt_q == CNT_MAX) begin
                armed_d = 1'b1;
            end else begin
                arm_cnt_d = arm_cnt_q + 1'b1;
            end
        end
        press_d = armed_q & level_q & ~level_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q   <= 1'b1;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            arm_cnt_q <= '0;
            press_q   <= 1'b0;
        end else begin
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            arm_cnt_q <= arm_cnt_d;
            press_q   <= press_d;
        end
    end

    assign level       = level_q;
    assign press_pulse = press_q;

endmodule

// File: rtl/bcd_date_entry.sv
// Digit-by-digit MMDDYY entry: synchronisers, per-key debounce, ENTRY/DONE FSM,
// packed-BCD digit register and month/day range check.
module bcd_date_entry
    import bcd_date_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  key_n,
    input  logic [3:0]  sw_digit,
    output logic [23:0] date_bcd,
    output logic [2:0]  cursor,
    output logic        date_done,
    output logic        date_valid,
    output logic        digit_err
);
    logic [1:0]  key_s1_q, key_s2_q;
    logic [3:0]  sw_s1_q, sw_s2_q;
    logic [1:0]  key_level;
    logic [1:0]  key_press;

    state_t      state_q, state_d;
    logic [2:0]  cursor_q, cursor_d;
    logic [23:0] date_q, date_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1_q <= 2'b11;
            key_s2_q <= 2'b11;
            sw_s1_q  <= 4'd0;
            sw_s2_q  <= 4'd0;
        end else begin
            key_s1_q <= key_n;
            key_s2_q <= key_s1_q;
            sw_s1_q  <= sw_digit;
            sw_s2_q  <= sw_s1_q;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk         (clk),
            .rst         (rst),
            .key_n_sync  (key_s2_q[k]),
            .level       (key_level[k]),
            .press_pulse (key_press[k])
        );
    end

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        date_d   = date_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        case (state_q)
            ST_ENTRY: begin
                // Backspace has priority; a simultaneous commit is dropped.
                if (key_press[1]) begin
                    if (cursor_q != 3'd0) begin
                        cursor_d = cursor_q - 3'd1;
                        for (int i = 0; i < DIGITS; i++) begin
                            if (cursor_q == 3'(i + 1)) date_d[23-4*i -: 4] = 4'd0;
                        end
                    end
                end else if (key_press[0]) begin
                    if (sw_s2_q > BCD_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < DIGITS; i++) begin
                            if (cursor_q == 3'(i)) date_d[23-4*i -: 4] = sw_s2_q;
                        end
                        cursor_d = cursor_q + 3'd1;
                        if (cursor_d == DONE_POS) begin
                            state_d = ST_DONE;
                            valid_d = range_ok(date_d);
                        end
                    end
                end
            end
            ST_DONE: begin
                if (key_press[1]) begin
                    state_d     = ST_ENTRY;
                    cursor_d    = LAST_POS;
                    date_d[3:0] = 4'd0;
                    valid_d     = 1'b0;
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ENTRY;
            cursor_q <= 3'd0;
            date_q   <= 24'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            date_q   <= date_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign date_bcd   = date_q;
    assign cursor     = cursor_q;
    assign date_done  = (state_q == ST_DONE);
    assign date_valid = valid_q;
    assign digit_err  = err_q;

endmodule

// File: tb/tb_bcd_date_entry.sv
// Self-checking bench for bcd_date_entry: a reference model computes the expected
// outputs of every key action, pushes them to a scoreboard queue and compares after settling.
module tb_bcd_date_entry;

    typedef struct packed {
        logic [23:0] date;
        logic [2:0]  cur;
        logic        done;
        logic        valid;
        logic [31:0] errs;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  key_n;
    logic [3:0]  sw_digit;
    logic [23:0] date_bcd;
    logic [2:0]  cursor;
    logic        date_done;
    logic        date_valid;
    logic        digit_err;

    int          n_tests;
    int          n_fail;
    int          err_cycles;
    exp_t        sb_q[$];

    logic [23:0] m_date;
    logic [2:0]  m_cur;
    logic        m_done;
    logic        m_valid;
    int          m_errs;

    bcd_date_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .sw_digit   (sw_digit),
        .date_bcd   (date_bcd),
        .cursor     (cursor),
        .date_done  (date_done),
        .date_valid (date_valid),
        .digit_err  (digit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) err_cycles <= 0;
        else if (digit_err) err_cycles <= err_cycles + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic model_range(input logic [23:0] d);
        return (d[23:16] >= 8'h01) && (d[23:16] <= 8'h12) &&
               (d[15:8] >= 8'h01) && (d[15:8] <= 8'h31);
    endfunction

    task automatic push_exp();
        exp_t e;
        e.date  = m_date;
        e.cur   = m_cur;
        e.done  = m_done;
        e.valid = m_valid;
        e.errs  = m_errs;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check_val({tag, "_date"},  {8'd0, date_bcd}, {8'd0, e.date});
        check_val({tag, "_cursor"}, {29'd0, cursor}, {29'd0, e.cur});
        check_val({tag, "_done"},  {31'd0, date_done}, {31'd0, e.done});
        check_val({tag, "_valid"}, {31'd0, date_valid}, {31'd0, e.valid});
        check_val({tag, "_errs"},  err_cycles, e.errs);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        key_n = 2'b11;
        cycles(3);
        rst = 1'b0;
        cycles(12);
        m_date = 24'd0; m_cur = 3'd0; m_done = 1'b0; m_valid = 1'b0; m_errs = 0;
    endtask

    task automatic model_bksp();
        if (m_done) begin
            m_done = 1'b0; m_valid = 1'b0; m_cur = 3'd5; m_date[3:0] = 4'd0;
        end else if (m_cur != 3'd0) begin
            m_cur = m_cur - 3'd1;
            m_date = m_date & ~(24'hF00000 >> (4 * m_cur));
        end
    endtask

    task automatic model_commit(input logic [3:0] v);
        if (m_done) return;
        if (v > 4'd9) begin
            m_errs++;
        end else begin
            m_date = m_date | ({v, 20'd0} >> (4 * m_cur));
            m_cur  = m_cur + 3'd1;
            if (m_cur == 3'd6) begin
                m_done  = 1'b1;
                m_valid = model_range(m_date);
            end
        end
    endtask

    task automatic press(input logic [1:0] mask);
        key_n = ~mask;
        cycles(10);
        key_n = 2'b11;
        cycles(10);
    endtask

    task automatic commit(input logic [3:0] v, input string tag);
        sw_digit = v;
        cycles(3);
        model_commit(v);
        push_exp();
        press(2'b01);
        pop_check(tag);
    endtask

    task automatic bksp(input string tag);
        model_bksp();
        push_exp();
        press(2'b10);
        pop_check(tag);
    endtask

    initial begin
        int pulse_len;
        n_tests = 0; n_fail = 0;
        rst = 1'b1; key_n = 2'b11; sw_digit = 4'd0;

        do_reset();
        push_exp();
        pop_check("reset");
        check_val("reset_err", {31'd0, digit_err}, 32'd0);

        // key held through reset release must not commit
        key_n = 2'b10; sw_digit = 4'd5;
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(20);
        key_n = 2'b11;
        cycles(15);
        push_exp();
        pop_check("held_rst");

        // bouncing commit
        sw_digit = 4'd3;
        cycles(3);
        key_n = 2'b10; cycles(1);
        key_n = 2'b11; cycles(1);
        key_n = 2'b10; cycles(1);
        key_n = 2'b11; cycles(1);
        key_n = 2'b10; cycles(10);
        key_n = 2'b11; cycles(10);
        model_commit(4'd3);
        push_exp();
        pop_check("bounce");
        check_val("bounce_word", {8'd0, date_bcd}, 32'h0030_0000);

        // valid date 07/12/01
        do_reset();
        commit(4'd0, "v0"); commit(4'd7, "v1"); commit(4'd1, "v2");
        commit(4'd2, "v3"); commit(4'd0, "v4"); commit(4'd1, "v5");
        check_val("valid_word", {8'd0, date_bcd}, 32'h0007_1201);
        check_val("valid_flag", {31'd0, date_valid}, 32'd1);
        commit(4'd5, "done_extra");

        // invalid date 13/32/99 then backspace out of DONE
        do_reset();
        commit(4'd1, "i0"); commit(4'd3, "i1"); commit(4'd3, "i2");
        commit(4'd2, "i3"); commit(4'd9, "i4"); commit(4'd9, "i5");
        check_val("inval_done", {31'd0, date_done}, 32'd1);
        bksp("done_bksp");
        check_val("bksp_word", {8'd0, date_bcd}, 32'h0013_3290);

        // rejected digit at cursor 2, pulse width exactly one cycle
        do_reset();
        commit(4'd1, "e0"); commit(4'd2, "e1");
        sw_digit = 4'hA;
        cycles(3);
        model_commit(4'hA);
        push_exp();
        key_n = 2'b10;
        pulse_len = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (digit_err) pulse_len++;
        end
        key_n = 2'b11;
        cycles(10);
        pop_check("bad_digit");
        check_val("err_pulse_len", pulse_len, 32'd1);

        // simultaneous keys at cursor 3: backspace wins
        commit(4'd5, "e2");
        sw_digit = 4'd8;
        cycles(3);
        model_bksp();
        push_exp();
        press(2'b11);
        pop_check("both_keys");
        check_val("both_word", {8'd0, date_bcd}, 32'h0012_0000);

        bksp("b1"); bksp("b0"); bksp("b_noop");
        check_val("noop_cursor", {29'd0, cursor}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
